cra_next_addr: RTL and testbench

- Microcode sequencer next-address stage; sits directly upstream of the control RAM address/field decode stage.
- Each advance cycle it computes the next CRAM address from the current microword's J field, dispatch code, skip condition, dispatch inputs and DRAM J, and registers it as crAdr.
- Holds a circular subroutine return stack for microcode CALL/RETURN.
- crAdr drives the control RAM read; the microword read back supplies j, disp, call and skip for the next cycle.

---
 rtl/cra_next_addr.sv | 115 +++++++++++
 tb/tb_cra_next_addr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cra_next_addr.sv
// Microcode sequencer next-address stage with a circular
// CALL/RETURN stack; crAdr feeds the control RAM read.
module cra_next_addr #(
    parameter int                 ADDR_W      = 11,
    parameter int                 STACK_DEPTH = 16,
    parameter logic [ADDR_W-1:0]  FORCE_ADDR  = 11'o1777
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              advance,
    input  logic              clkForce1777,
    input  logic [ADDR_W-1:0] j,
    input  logic [4:0]        disp,
    input  logic              call,
    input  logic              skipCond,
    input  logic [3:0]        dispIn,
    input  logic [ADDR_W-2:0] dramJ,
    output logic [ADDR_W-1:0] crAdr,
    output logic [$clog2(STACK_DEPTH):0] stackDepth,
    output logic              stackOvf,
    output logic              stackUnf,
    output logic [ADDR_W-1:0] retAddr
);

    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int DEP_W = SP_W + 1;

    localparam logic [4:0] D_SKIP = 5'h01;
    localparam logic [4:0] D_DISP = 5'h02;
    localparam logic [4:0] D_DRAM = 5'h03;
    localparam logic [4:0] D_RET  = 5'h04;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp, sp_top, sp_pop, sp_nxt;
    logic [DEP_W-1:0]  depth, depth_pop, depth_nxt;
    logic [ADDR_W-1:0] top, nxt;
    logic              ovf_set, unf_set;
    logic              is_skip, is_disp, is_dram, is_ret;

    assign sp_top = sp - SP_W'(1);
    assign top    = (depth != '0) ? mem[sp_top] : '0;

    // force overrides disp, so decode flags are mutually exclusive
    assign is_skip = !clkForce1777 && (disp == D_SKIP);
    assign is_disp = !clkForce1777 && (disp == D_DISP);
    assign is_dram = !clkForce1777 && (disp == D_DRAM);
    assign is_ret  = !clkForce1777 && (disp == D_RET);

    always_comb begin
        sp_pop    = sp;
        depth_pop = depth;
        unf_set   = 1'b0;
        if (is_ret) begin
            if (depth != '0) begin
                sp_pop    = sp_top;
                depth_pop = depth - DEP_W'(1);
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    always_comb begin
        nxt = j;
        unique case (1'b1)
            clkForce1777: nxt = FORCE_ADDR;
            is_skip: nxt = j | {{(ADDR_W-1){1'b0}}, skipCond};
            is_disp: nxt = j | {{(ADDR_W-4){1'b0}}, dispIn};
            is_dram: nxt = {j[ADDR_W-1], dramJ};
            is_ret:  nxt = top | j;
            default: nxt = j;
        endcase
    end

    // push lands in the slot the pop (if any) just freed
    always_comb begin
        sp_nxt    = sp_pop;
        depth_nxt = depth_pop;
        ovf_set   = 1'b0;
        if (call) begin
            sp_nxt = sp_pop + SP_W'(1);
            if (depth_pop == DEP_W'(STACK_DEPTH)) begin
                ovf_set = 1'b1;
            end else begin
                depth_nxt = depth_pop + DEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            crAdr    <= '0;
            sp       <= '0;
            depth    <= '0;
            stackOvf <= 1'b0;
            stackUnf <= 1'b0;
        end else if (advance) begin
            crAdr <= nxt;
            sp    <= sp_nxt;
            depth <= depth_nxt;
            if (ovf_set) stackOvf <= 1'b1;
            if (unf_set) stackUnf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && call) begin
            mem[sp_pop] <= crAdr;
        end
    end

    assign stackDepth = depth;
    assign retAddr    = top;

endmodule

// File: tb/tb_cra_next_addr.sv
// Bench for cra_next_addr: directed plan plus random
// stimulus against a queue-based return stack model.
module tb_cra_next_addr;

    logic        clk = 1'b0;
    logic        resetN;
    logic        advance;
    logic        clkForce1777;
    logic [10:0] j;
    logic [4:0]  disp;
    logic        call;
    logic        skipCond;
    logic [3:0]  dispIn;
    logic [9:0]  dramJ;
    logic [10:0] crAdr;
    logic [4:0]  stackDepth;
    logic        stackOvf;
    logic        stackUnf;
    logic [10:0] retAddr;

    int total = 0;
    int bad   = 0;

    logic [10:0] m_cr;
    logic [10:0] m_q[$];
    logic        m_ovf, m_unf;

    cra_next_addr dut (
        .clk(clk), .resetN(resetN), .advance(advance),
        .clkForce1777(clkForce1777), .j(j), .disp(disp),
        .call(call), .skipCond(skipCond), .dispIn(dispIn),
        .dramJ(dramJ), .crAdr(crAdr), .stackDepth(stackDepth),
        .stackOvf(stackOvf), .stackUnf(stackUnf), .retAddr(retAddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0o exp=%0o", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_cr = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic m_step();
        logic [10:0] t, n;
        if (!advance) return;
        t = 11'd0;
        if (!clkForce1777 && disp == 5'd4) begin
            if (m_q.size() > 0) t = m_q.pop_back();
            else m_unf = 1'b1;
        end
        if (clkForce1777)      n = 11'o1777;
        else if (disp == 5'd1) n = j | 11'(skipCond);
        else if (disp == 5'd2) n = j | 11'(dispIn);
        else if (disp == 5'd3) n = {j[10], dramJ};
        else if (disp == 5'd4) n = t | j;
        else                   n = j;
        if (call) begin
            if (m_q.size() == 16) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            m_q.push_back(m_cr);
        end
        m_cr = n;
    endtask

    task automatic chk_all(input string tag);
        logic [10:0] r;
        r = (m_q.size() > 0) ? m_q[$] : 11'd0;
        chk({tag, ".cr"},  32'(crAdr), 32'(m_cr));
        chk({tag, ".dep"}, 32'(stackDepth), 32'(m_q.size()));
        chk({tag, ".ovf"}, 32'(stackOvf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(stackUnf), 32'(m_unf));
        chk({tag, ".ret"}, 32'(retAddr), 32'(r));
    endtask

    task automatic cyc(input string tag, input logic adv,
                       input logic frc, input logic [10:0] jv,
                       input logic [4:0] dv, input logic cl,
                       input logic sk, input logic [3:0] di,
                       input logic [9:0] dj);
        advance = adv; clkForce1777 = frc; j = jv; disp = dv;
        call = cl; skipCond = sk; dispIn = di; dramJ = dj;
        @(posedge clk);
        m_step();
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        #1;
        m_reset();
        chk_all("rst");
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b1;
        advance = 0; clkForce1777 = 0; j = 0; disp = 0;
        call = 0; skipCond = 0; dispIn = 0; dramJ = 0;
        m_reset();
        #2;
        resetN = 1'b0;
        #1;
        chk_all("por");
        @(negedge clk);
        resetN = 1'b1;

        cyc("seq",  1, 0, 11'o0100, 0, 0, 0, 0, 0);
        chk("seq_lit", 32'(crAdr), 32'(11'o0100));
        cyc("skip", 1, 0, 11'o0200, 1, 0, 1, 0, 0);
        chk("skip_lit", 32'(crAdr), 32'(11'o0201));
        cyc("disp", 1, 0, 11'o0300, 2, 0, 0, 4'hA, 0);
        chk("disp_lit", 32'(crAdr), 32'(11'o0312));
        cyc("dram", 1, 0, 11'o2000, 3, 0, 0, 0, 10'o0555);
        chk("dram_lit", 32'(crAdr), 32'(11'o2555));

        cyc("to400", 1, 0, 11'o0400, 0, 0, 0, 0, 0);
        cyc("call",  1, 0, 11'o1000, 0, 1, 0, 0, 0);
        chk("call_ret", 32'(retAddr), 32'(11'o0400));
        cyc("ret",   1, 0, 11'o0001, 4, 0, 0, 0, 0);
        chk("ret_lit", 32'(crAdr), 32'(11'o0401));

        cyc("to1", 1, 0, 11'd1, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 18; i++)
            cyc("ovcall", 1, 0, 11'(i), 0, 1, 0, 0, 0);
        chk("ovf_dep", 32'(stackDepth), 32'd16);
        chk("ovf_flag", 32'(stackOvf), 32'd1);
        for (int i = 17; i >= 2; i--) begin
            cyc("pop", 1, 0, 11'd0, 4, 0, 0, 0, 0);
            chk("pop_lit", 32'(crAdr), 32'(i));
        end
        cyc("unf", 1, 0, 11'd0, 4, 0, 0, 0, 0);
        chk("unf_flag", 32'(stackUnf), 32'd1);

        cyc("c1", 1, 0, 11'o0010, 0, 1, 0, 0, 0);
        cyc("c2", 1, 0, 11'o0020, 0, 1, 0, 0, 0);
        cyc("force", 1, 1, 11'o0003, 4, 0, 0, 0, 0);
        chk("force_lit", 32'(crAdr), 32'(11'o1777));
        chk("force_dep", 32'(stackDepth), 32'd2);
        for (int i = 0; i < 5; i++)
            cyc("hold", 0, 0, 11'($urandom), 5'($urandom_range(0, 4)),
                1'($urandom), 1, 4'($urandom), 10'($urandom));

        cyc("c3", 1, 0, 11'o0030, 4, 1, 0, 0, 0);
        cyc("c4", 1, 0, 11'o0040, 0, 1, 0, 0, 0);
        chk("pre_ar_dep", 32'(stackDepth), 32'd3);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc("rnd",
                    1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 19) == 0),
                    11'($urandom),
                    5'($urandom_range(0, 3) == 0 ? $urandom
                                                 : $urandom_range(0, 5)),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom), 4'($urandom), 10'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
